// File: rtl/fmdll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fmdll_lock_ctrl
// Description : Delay-code controller for the frequency-multiplying DLL.
//               Performs a binary (SAR) coarse search of the DCDL code in
//               open loop. It then tracks the code by +/-1 in closed loop.
//               A settle window follows every code change. The block also
//               detects lock and loss of lock, saturates the code at both
//               ends, and relocks automatically when the M/N ratio changes.
//
// Ports       : clk_ext  in   reference clock, sole clock of the block
//               rst_n    in   synchronous active-low reset
//               en       in   controller enable, 0 forces IDLE
//               div_m    in   M ratio [M_W]
//               mult_n   in   N ratio [N_W]
//               pd_valid in   phase-detector result valid this cycle
//               pd_up    in   1 = delay too short (raise code), 0 = too long
//               freeze   in   (FMDLL_FREEZE_EN only) hold tracking in TRACK
//               code     out  DCDL control code [CODE_W]
//               sel      out  00 closed loop, 01 open loop, 10 gated
//               locked   out  lock indication
//               busy     out  1 while the SAR search runs
//
// Options     : define FMDLL_FREEZE_EN to add the freeze input.
//
// Revision    : 1.0  initial release
// ============================================================================
module fmdll_lock_ctrl #(
    parameter int M_W      = 2,
    parameter int N_W      = 4,
    parameter int CODE_W   = 10,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              en,
    input  logic [M_W-1:0]    div_m,
    input  logic [N_W-1:0]    mult_n,
    input  logic              pd_valid,
    input  logic              pd_up,
`ifdef FMDLL_FREEZE_EN
    input  logic              freeze,
`endif
    output logic [CODE_W-1:0] code,
    output logic [1:0]        sel,
    output logic              locked,
    output logic              busy
);

    localparam int c_SETTLE_W = $clog2(SETTLE + 1);
    localparam int c_LOCK_W   = $clog2(LOCK_CNT + 1);
    localparam int c_BIT_W    = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SAR   = 2'd1;
    localparam logic [1:0] c_ST_TRACK = 2'd2;

    localparam logic [1:0] c_SEL_CLOSED = 2'b00;
    localparam logic [1:0] c_SEL_OPEN   = 2'b01;
    localparam logic [1:0] c_SEL_GATED  = 2'b10;

    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LD = c_SETTLE_W'(SETTLE);
    localparam logic [c_LOCK_W-1:0]   c_LOCK_MAX  = c_LOCK_W'(LOCK_CNT);
    localparam logic [c_LOCK_W-1:0]   c_LOCK_ONE  = c_LOCK_W'(1);
    localparam logic [CODE_W-1:0]     c_CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0]     c_CODE_ONE  = CODE_W'(1);
    localparam logic [CODE_W-1:0]     c_CODE_MSB  = CODE_W'(1) << (CODE_W - 1);
    localparam logic [c_BIT_W-1:0]    c_BIT_TOP   = c_BIT_W'(CODE_W - 1);
    localparam logic [c_BIT_W-1:0]    c_BIT_ONE   = c_BIT_W'(1);

    logic [1:0]            r_state,    w_state_nxt;
    logic [CODE_W-1:0]     r_code,     w_code_nxt;
    logic [1:0]            r_sel,      w_sel_nxt;
    logic                  r_locked,   w_locked_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic [c_BIT_W-1:0]    r_bit,      w_bit_nxt;
    logic [c_SETTLE_W-1:0] r_settle,   w_settle_nxt;
    logic [c_LOCK_W-1:0]   r_lock_run, w_lock_run_nxt;   // length of current alternating run
    logic [c_LOCK_W-1:0]   r_loss_run, w_loss_run_nxt;   // length of current same-direction run
    logic                  r_last_up,  w_last_up_nxt;
    logic                  r_have_dir, w_have_dir_nxt;   // a TRACK result exists to compare against
    logic [M_W-1:0]        r_div_m,    w_div_m_nxt;
    logic [N_W-1:0]        r_mult_n,   w_mult_n_nxt;

    logic                  w_frozen;
    logic                  w_accept;
    logic                  w_cfg_chg;
    logic [CODE_W-1:0]     w_bit_mask;
    logic [CODE_W-1:0]     w_sar_res;

`ifdef FMDLL_FREEZE_EN
    assign w_frozen = freeze && (r_state == c_ST_TRACK);
`else
    assign w_frozen = 1'b0;
`endif

    assign w_accept   = pd_valid && (r_settle == '0) && !w_frozen;
    assign w_cfg_chg  = (div_m != r_div_m) || (mult_n != r_mult_n);
    assign w_bit_mask = c_CODE_ONE << r_bit;
    // Keep the trial bit when the delay is still too short, otherwise drop it.
    assign w_sar_res  = pd_up ? r_code : (r_code & ~w_bit_mask);

    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_code     <= '0;
            r_sel      <= c_SEL_GATED;
            r_locked   <= 1'b0;
            r_busy     <= 1'b0;
            r_bit      <= '0;
            r_settle   <= '0;
            r_lock_run <= '0;
            r_loss_run <= '0;
            r_last_up  <= 1'b0;
            r_have_dir <= 1'b0;
            r_div_m    <= '0;
            r_mult_n   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_sel      <= w_sel_nxt;
            r_locked   <= w_locked_nxt;
            r_busy     <= w_busy_nxt;
            r_bit      <= w_bit_nxt;
            r_settle   <= w_settle_nxt;
            r_lock_run <= w_lock_run_nxt;
            r_loss_run <= w_loss_run_nxt;
            r_last_up  <= w_last_up_nxt;
            r_have_dir <= w_have_dir_nxt;
            r_div_m    <= w_div_m_nxt;
            r_mult_n   <= w_mult_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_sel_nxt      = r_sel;
        w_locked_nxt   = r_locked;
        w_busy_nxt     = r_busy;
        w_bit_nxt      = r_bit;
        w_settle_nxt   = r_settle;
        w_lock_run_nxt = r_lock_run;
        w_loss_run_nxt = r_loss_run;
        w_last_up_nxt  = r_last_up;
        w_have_dir_nxt = r_have_dir;
        w_div_m_nxt    = r_div_m;
        w_mult_n_nxt   = r_mult_n;

        // Settle countdown; a frozen loop holds it along with everything else.
        if ((r_state != c_ST_IDLE) && (r_settle != '0) && !w_frozen) begin
            w_settle_nxt = r_settle - c_SETTLE_W'(1);
        end

        case (r_state)
            c_ST_IDLE: begin
                w_code_nxt     = '0;
                w_sel_nxt      = c_SEL_GATED;
                w_locked_nxt   = 1'b0;
                w_busy_nxt     = 1'b0;
                w_settle_nxt   = '0;
                w_lock_run_nxt = '0;
                w_loss_run_nxt = '0;
                w_have_dir_nxt = 1'b0;
                w_div_m_nxt    = div_m;
                w_mult_n_nxt   = mult_n;
                if (en && (div_m != '0) && (mult_n != '0)) begin
                    w_state_nxt  = c_ST_SAR;
                    w_code_nxt   = c_CODE_MSB;
                    w_sel_nxt    = c_SEL_OPEN;
                    w_busy_nxt   = 1'b1;
                    w_bit_nxt    = c_BIT_TOP;
                    w_settle_nxt = c_SETTLE_LD;
                end
            end

            c_ST_SAR: begin
                if (w_accept) begin
                    w_settle_nxt = c_SETTLE_LD;
                    if (r_bit != '0) begin
                        w_code_nxt = w_sar_res | (w_bit_mask >> 1);
                        w_bit_nxt  = r_bit - c_BIT_ONE;
                    end else begin
                        w_state_nxt    = c_ST_TRACK;
                        w_code_nxt     = w_sar_res;
                        w_sel_nxt      = c_SEL_CLOSED;
                        w_busy_nxt     = 1'b0;
                        w_lock_run_nxt = '0;
                        w_loss_run_nxt = '0;
                        w_have_dir_nxt = 1'b0;
                    end
                end
            end

            c_ST_TRACK: begin
                if (w_accept) begin
                    w_settle_nxt   = c_SETTLE_LD;
                    w_last_up_nxt  = pd_up;
                    w_have_dir_nxt = 1'b1;
                    if (pd_up && (r_code != c_CODE_MAX)) begin
                        w_code_nxt = r_code + c_CODE_ONE;
                    end else if (!pd_up && (r_code != '0)) begin
                        w_code_nxt = r_code - c_CODE_ONE;
                    end

                    // Both runs include the current result, so the first
                    // result of a run counts as 1.
                    if (r_have_dir && (pd_up != r_last_up)) begin
                        w_lock_run_nxt = (r_lock_run == c_LOCK_MAX) ? r_lock_run
                                                                    : r_lock_run + c_LOCK_ONE;
                        w_loss_run_nxt = c_LOCK_ONE;
                    end else if (r_have_dir) begin
                        w_lock_run_nxt = c_LOCK_ONE;
                        w_loss_run_nxt = (r_loss_run == c_LOCK_MAX) ? r_loss_run
                                                                    : r_loss_run + c_LOCK_ONE;
                    end else begin
                        w_lock_run_nxt = c_LOCK_ONE;
                        w_loss_run_nxt = c_LOCK_ONE;
                    end

                    if (w_lock_run_nxt == c_LOCK_MAX) begin
                        w_locked_nxt = 1'b1;
                    end else if (r_locked && (w_loss_run_nxt == c_LOCK_MAX)) begin
                        w_locked_nxt = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Disable or ratio change overrides any result taken this cycle.
        if ((r_state != c_ST_IDLE) && (!en || w_cfg_chg)) begin
            w_state_nxt    = c_ST_IDLE;
            w_code_nxt     = '0;
            w_sel_nxt      = c_SEL_GATED;
            w_locked_nxt   = 1'b0;
            w_busy_nxt     = 1'b0;
            w_settle_nxt   = '0;
            w_lock_run_nxt = '0;
            w_loss_run_nxt = '0;
            w_have_dir_nxt = 1'b0;
        end
    end

    assign code   = r_code;
    assign sel    = r_sel;
    assign locked = r_locked;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fmdll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmdll_lock_ctrl
// Description : Directed scoreboard bench for fmdll_lock_ctrl. Stimulus tasks
//               queue the outputs expected after each clock edge. A monitor
//               pops them and compares on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fmdll_lock_ctrl;

    localparam int M_W      = 2;
    localparam int N_W      = 4;
    localparam int CODE_W   = 10;
    localparam int SETTLE   = 4;
    localparam int LOCK_CNT = 8;

    logic              clk_ext;
    logic              rst_n;
    logic              en;
    logic [M_W-1:0]    div_m;
    logic [N_W-1:0]    mult_n;
    logic              pd_valid;
    logic              pd_up;
`ifdef FMDLL_FREEZE_EN
    logic              freeze;
`endif
    logic [CODE_W-1:0] code;
    logic [1:0]        sel;
    logic              locked;
    logic              busy;

    typedef struct {
        int          cyc;
        string       name;
        logic [9:0]  code;
        logic [1:0]  sel;
        logic        locked;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fmdll_lock_ctrl #(
        .M_W      (M_W),
        .N_W      (N_W),
        .CODE_W   (CODE_W),
        .SETTLE   (SETTLE),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk_ext  (clk_ext),
        .rst_n    (rst_n),
        .en       (en),
        .div_m    (div_m),
        .mult_n   (mult_n),
        .pd_valid (pd_valid),
        .pd_up    (pd_up),
`ifdef FMDLL_FREEZE_EN
        .freeze   (freeze),
`endif
        .code     (code),
        .sel      (sel),
        .locked   (locked),
        .busy     (busy)
    );

    initial begin
        clk_ext = 1'b0;
        forever #5 clk_ext = ~clk_ext;
    end

    always @(posedge clk_ext) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk_ext) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || code !== e.code || sel !== e.sel ||
                locked !== e.locked || busy !== e.busy) begin
                errors++;
                $display("FAIL %s @cyc %0d: got code=%h sel=%b locked=%b busy=%b, expected code=%h sel=%b locked=%b busy=%b (due cyc %0d)",
                         e.name, cyc, code, sel, locked, busy,
                         e.code, e.sel, e.locked, e.busy, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got time %0t, required < 200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_ext);
        #1;
    endtask

    // Expected outputs after the next active edge.
    task automatic expect_next(input string nm, input logic [9:0] c, input logic [1:0] s,
                               input logic l, input logic b);
        exp_t e;
        e.cyc    = cyc + 1;
        e.name   = nm;
        e.code   = c;
        e.sel    = s;
        e.locked = l;
        e.busy   = b;
        sb.push_back(e);
    endtask

    // Full SAR search starting from IDLE. The detector reports "raise" while
    // the trial code is at or below the target. pd_valid stays high through
    // every settle window so ignored results are exercised. The final code is
    // supplied separately as a hand-computed value.
    task automatic sar_run(input logic [9:0] target, input logic [9:0] exp_final);
        logic [9:0] trial;
        logic [9:0] res;
        trial = 10'h200;
        pd_valid = 1'b1;
        expect_next("sar_entry", trial, 2'b01, 1'b0, 1'b1);
        step();
        for (int b = 9; b >= 0; b--) begin
            repeat (SETTLE) begin
                pd_up = 1'($urandom_range(0, 1));
                expect_next("sar_settle", trial, 2'b01, 1'b0, 1'b1);
                step();
            end
            pd_up = (trial <= target);
            res = pd_up ? trial : (trial & ~(10'(1) << b));
            if (b > 0) begin
                trial = res | (10'(1) << (b - 1));
                expect_next("sar_bit", trial, 2'b01, 1'b0, 1'b1);
            end else begin
                expect_next("sar_done", exp_final, 2'b00, 1'b0, 1'b0);
            end
            step();
        end
        repeat (SETTLE) begin
            pd_up = 1'($urandom_range(0, 1));
            expect_next("track_entry_settle", exp_final, 2'b00, 1'b0, 1'b0);
            step();
        end
        pd_valid = 1'b0;
    endtask

    // One accepted TRACK result, then the settle window with opposite-direction
    // results that must be ignored.
    task automatic track_result(input logic dir, input logic [9:0] ec, input logic el);
        pd_valid = 1'b1;
        pd_up    = dir;
        expect_next("track_step", ec, 2'b00, el, 1'b0);
        step();
        repeat (SETTLE) begin
            pd_up = ~dir;
            expect_next("track_settle", ec, 2'b00, el, 1'b0);
            step();
        end
        pd_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_m    = 2'd1;
        mult_n   = 4'd4;
        pd_valid = 1'b0;
        pd_up    = 1'b0;
`ifdef FMDLL_FREEZE_EN
        freeze   = 1'b0;
`endif
        expect_next("reset0", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        expect_next("reset1", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        en    = 1'b1;

        // Coarse search onto 0x2B5.
        sar_run(10'h2B5, 10'h2B5);

        // Alternating up/down around 0x2B5: lock on the 8th result.
        for (int i = 0; i < 8; i++)
            track_result(i % 2 == 0, (i % 2 == 0) ? 10'h2B6 : 10'h2B5, i == 7);

        // Eight raises in a row: lock lost on the 8th, code keeps stepping.
        for (int i = 0; i < 8; i++)
            track_result(1'b1, 10'(10'h2B6 + i), i != 7);

        // Reset mid-TRACK, held two cycles, with a live result on the inputs.
        rst_n    = 1'b0;
        pd_valid = 1'b1;
        pd_up    = 1'b1;
        expect_next("rst_track0", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        expect_next("rst_track1", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        rst_n    = 1'b1;
        pd_valid = 1'b0;

        // Search with every result "lower": ends at code 0.
        sar_run(10'h000, 10'h000);

        // Lock around 1/0, then a lower request at code 0 saturates.
        for (int i = 0; i < 8; i++)
            track_result(i % 2 == 0, (i % 2 == 0) ? 10'h001 : 10'h000, i == 7);
        track_result(1'b0, 10'h000, 1'b1);

        // Ratio change while locked, with a result present: change wins.
        mult_n   = 4'd6;
        pd_valid = 1'b1;
        pd_up    = 1'b1;
        expect_next("ratio_idle", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        pd_valid = 1'b0;

        // New search with every result "higher": ends at full scale.
        sar_run(10'h3FF, 10'h3FF);
        for (int i = 0; i < 3; i++)
            track_result(1'b1, 10'h3FF, 1'b0);

`ifdef FMDLL_FREEZE_EN
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pd_valid = 1'b1;
            pd_up    = 1'b0;
            expect_next("freeze_hold", 10'h3FF, 2'b00, 1'b0, 1'b0);
            step();
            pd_valid = 1'b0;
            expect_next("freeze_hold_gap", 10'h3FF, 2'b00, 1'b0, 1'b0);
            step();
        end
        freeze = 1'b0;
        track_result(1'b0, 10'h3FE, 1'b0);
`endif

        // div_m = 0: leave TRACK and stay in IDLE.
        div_m = 2'd0;
        expect_next("cfg_idle", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        repeat (4) begin
            pd_valid = 1'b1;
            expect_next("stay_idle_m0", 10'h000, 2'b10, 1'b0, 1'b0);
            step();
        end
        pd_valid = 1'b0;

        // Valid ratio but disabled: still IDLE.
        div_m = 2'd1;
        en    = 1'b0;
        repeat (3) begin
            expect_next("stay_idle_en0", 10'h000, 2'b10, 1'b0, 1'b0);
            step();
        end

        // Enable restarts the search, then dropping en aborts it.
        en = 1'b1;
        expect_next("restart_sar", 10'h200, 2'b01, 1'b0, 1'b1);
        step();
        en       = 1'b0;
        pd_valid = 1'b1;
        expect_next("en_drop", 10'h000, 2'b10, 1'b0, 1'b0);
        step();
        pd_valid = 1'b0;

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
